// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM word, RAM handshake state, and memory arbiter FSM state.
// Pure type package; no logic.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_grant_timer.sv
// Grant watchdog: counts cycles spent in a grant and raises a sticky timeout_err once a
// grant has lasted TIMEOUT_CYC cycles (flag visible the cycle after); never aborts the grant.
module arb_grant_timer #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic CLK,
    input  logic nRST,
    input  logic in_grant,
    output logic timeout_err
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TO_LIM  = CW'(TIMEOUT_CYC);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] to_cnt;
    logic          hit;

    // hit marks the edge on which to_cnt reaches TIMEOUT_CYC
    assign hit = in_grant && (to_cnt == TO_LAST);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            to_cnt <= '0;
        end else if (!in_grant) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_LIM) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            timeout_err <= 1'b0;
        end else if (hit) begin
            timeout_err <= 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Registered icache/dcache arbiter for the single RAM port; 1-cycle arbitration, grant held to ACCESS.
// Default: dcache priority with STARVE_MAX guard; `define ARB_RR_EN for strict round-robin.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX  = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      timeout_err
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    arb_state_t    state, state_nxt;
    logic [SW-1:0] starve_cnt;
    logic          dreq;
    logic          d_pick;
    logic          i_done;
    logic          d_done;
    logic          grant_active;

    assign dreq         = dREN | dWEN;
    assign grant_active = (state != IDLE);

`ifdef ARB_RR_EN
    logic last_d;

    assign starve_cnt = '0;
    assign d_pick     = dreq && (!iREN || !last_d);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_d <= 1'b0;
        end else if (d_done) begin
            last_d <= 1'b1;
        end else if (i_done) begin
            last_d <= 1'b0;
        end
    end
`else
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    assign d_pick = dreq && (starve_cnt < STARVE_LIM);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve_cnt <= '0;
        end else if (!iREN || i_done) begin
            starve_cnt <= '0;
        end else if (d_done && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // RAM enables follow the granted side's request live, so a dropped request releases the RAM at once
    always_comb begin
        state_nxt = state;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        iwait     = 1'b1;
        iload     = '0;
        dwait     = 1'b1;
        dload     = '0;
        i_done    = 1'b0;
        d_done    = 1'b0;

        case (state)
            IDLE: begin
                if (d_pick) begin
                    state_nxt = DGNT;
                end else if (iREN) begin
                    state_nxt = IGNT;
                end
            end

            IGNT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (!iREN) begin
                    state_nxt = IDLE;
                end else if (ramstate == ACCESS) begin
                    iwait     = 1'b0;
                    iload     = ramload;
                    i_done    = 1'b1;
                    state_nxt = IDLE;
                end else if (ramstate == ERROR) begin
                    state_nxt = IDLE;
                end
            end

            DGNT: begin
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (!dreq) begin
                    state_nxt = IDLE;
                end else if (ramstate == ACCESS) begin
                    dwait     = 1'b0;
                    dload     = dREN ? ramload : '0;
                    d_done    = 1'b1;
                    state_nxt = IDLE;
                end else if (ramstate == ERROR) begin
                    state_nxt = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    arb_grant_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_grant_timer (
        .CLK         (CLK),
        .nRST        (nRST),
        .in_grant    (grant_active),
        .timeout_err (timeout_err)
    );

endmodule
